// File: rtl/fp_normalize_round.sv
// fp_normalize_round: post-add normalise/round stage of the FP adder.
// Stage 1 normalises the raw sum mantissa, stage 2 rounds and packs an
// IEEE-754 binary32 result with RISC-V fflags. Subnormals flush to zero.
// Optional feature macro: FP_NORM_RM_EN adds the rm port and the RTZ, RDN,
// RUP and RMM rounding modes; without it only RNE is implemented.
module fp_normalize_round #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int LZ_W  = $clog2(MAN_W + 4) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic signed [EXP_W+1:0]  in_exp,
   input  logic [MAN_W+4:0]         in_mant,
   input  logic [LZ_W-1:0]          lead_pos,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_result,
   output logic [4:0]               out_flags
`ifdef FP_NORM_RM_EN
   ,
   input  logic [2:0]               rm
`endif
);

   // normalised mantissa width: hidden + fraction + G,R,S
   localparam int MW = MAN_W + 4;
   // one extra exponent bit so in_exp+1 and rounding carries cannot wrap
   localparam int EW = EXP_W + 3;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

   logic                 s1_adv, s2_adv;
   logic                 s1_valid, s2_valid;
   logic                 s1_sign, s1_zero, s1_flush;
   logic signed [EW-1:0] s1_exp;
   logic [MW-1:0]        s1_mant;

   logic signed [EW-1:0] in_exp_x, n_exp;
   logic [MW-1:0]        n_mant;
   logic [LZ_W-1:0]      sh;
   logic                 n_zero, n_flush;

   rm_e                  mode;
   logic                 inexact, inc, away, ovf;
   logic [MAN_W+1:0]     rounded;
   logic signed [EW-1:0] r_exp;
   logic [MAN_W-1:0]     r_frac;
   logic [EXP_W+MAN_W:0] nxt_result;
   logic [4:0]           nxt_flags;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;
   assign in_exp_x  = {{(EW-EXP_W-2){in_exp[EXP_W+1]}}, in_exp};

`ifdef FP_NORM_RM_EN
   logic [2:0] s1_rm;
   assign mode = rm_e'(s1_rm);
`else
   assign mode = RM_RNE;
`endif

   // Normalise: absorb a carry with a sticky right shift, otherwise left-shift the leading one to the hidden position
   always_comb begin
      sh      = LZ_W'(MW - 1) - lead_pos;
      n_mant  = '0;
      n_exp   = in_exp_x;
      n_zero  = 1'b0;
      n_flush = 1'b0;
      if (in_mant[MW]) begin
         n_mant = {in_mant[MW:2], in_mant[1] | in_mant[0]};
         n_exp  = in_exp_x + EW'(1);
      end else if (lead_pos == '1) begin
         n_zero = 1'b1;
      end else begin
         n_mant = in_mant[MW-1:0] << sh;
         n_exp  = in_exp_x - EW'(sh);
      end
      if (!n_zero && (n_exp[EW-1] || n_exp == '0)) begin
         n_flush = 1'b1;
      end
   end

   // Stage 1 register: loads whenever the stage is empty or its beat moves on
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_mant  <= '0;
         s1_zero  <= 1'b0;
         s1_flush <= 1'b0;
`ifdef FP_NORM_RM_EN
         s1_rm    <= 3'b000;
`endif
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= in_sign;
            s1_exp   <= n_exp;
            s1_mant  <= n_mant;
            s1_zero  <= n_zero;
            s1_flush <= n_flush;
`ifdef FP_NORM_RM_EN
            s1_rm    <= rm;
`endif
         end
      end
   end

   // Round and pack: pick the increment for the mode, fold a carry out of the hidden bit into the exponent, then classify
   always_comb begin
      inexact = s1_mant[2] | s1_mant[1] | s1_mant[0];
      inc     = 1'b0;
      away    = 1'b1;
      case (mode)
         RM_RTZ: begin
            inc  = 1'b0;
            away = 1'b0;
         end
         RM_RDN: begin
            inc  = inexact & s1_sign;
            away = s1_sign;
         end
         RM_RUP: begin
            inc  = inexact & !s1_sign;
            away = !s1_sign;
         end
         RM_RMM: inc = s1_mant[2];
         default: inc = s1_mant[2] & (s1_mant[1] | s1_mant[0] | s1_mant[3]);
      endcase
      rounded = {1'b0, s1_mant[MW-1:3]} + (MAN_W+2)'(inc);
      r_exp   = s1_exp + EW'(rounded[MAN_W+1]);
      r_frac  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
      ovf     = !r_exp[EW-1] && (r_exp >= EW'((1 << EXP_W) - 1));
      nxt_result = {s1_sign, r_exp[EXP_W-1:0], r_frac};
      nxt_flags  = {4'b0000, inexact};
      if (s1_zero) begin
         nxt_result = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
         nxt_flags  = 5'b00000;
      end else if (s1_flush) begin
         nxt_result = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
         nxt_flags  = 5'b00011;
      end else if (ovf) begin
         nxt_flags = 5'b00101;
         if (away) begin
            nxt_result = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end else begin
            nxt_result = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         end
      end
   end

   // Stage 2 register: holds the result stable until downstream accepts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= nxt_result;
            out_flags  <= nxt_flags;
         end
      end
   end

endmodule
